// File: rtl/onehot_decoder_buf.sv
// Registered N-to-2^N one-hot decoder with a 2-entry output buffer.
// Codes enter on a valid/ready handshake, are decoded to one-hot, and
// leave through a second valid/ready handshake in strict FIFO order.
// A wrapping 8-bit counter tracks the number of words delivered.
module onehot_decoder_buf #(
    parameter int N = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                in_valid,
    input  logic [N-1:0]        in_code,
    output logic                in_ready,
    output logic                out_valid,
    output logic [(1<<N)-1:0]   out_onehot,
    input  logic                out_ready,
    output logic [7:0]          pop_count
);

    localparam int W = 1 << N;

    // Buffer state: head is the word presented downstream, tail is the
    // second slot. Unoccupied slots are always kept at zero.
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   occ_q, occ_d;
    logic [7:0]   pop_count_q, pop_count_d;

    logic [W-1:0] dec_word;
    logic         push;
    logic         pop;

    // One comparator per output line; every code hits exactly one line.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_dec
            assign dec_word[gi] = (in_code == N'(gi));
        end
    endgenerate

    assign in_ready   = en & (occ_q < 2'd2);
    assign out_valid  = (occ_q != 2'd0);
    assign out_onehot = out_valid ? head_q : '0;
    assign pop_count  = pop_count_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Next-state for the two-slot buffer and the delivery counter.
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        occ_d       = occ_q;
        pop_count_d = pop_count_q;

        if (pop) begin
            pop_count_d = pop_count_q + 8'd1;
        end

        unique case ({push, pop})
            2'b10: begin
                // Push only: fill the first free slot.
                if (occ_q == 2'd0) begin
                    head_d = dec_word;
                end else begin
                    tail_d = dec_word;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                // Pop only: tail (zero if unused) moves up to head.
                head_d = tail_q;
                tail_d = '0;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Both at once can only happen with one word buffered
                // (push needs a free slot, pop needs a word), so the new
                // word replaces the departing head.
                head_d = dec_word;
            end
            default: begin
            end
        endcase
    end

    // State registers; reset clears everything without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            occ_q       <= 2'd0;
            pop_count_q <= 8'd0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            occ_q       <= occ_d;
            pop_count_q <= pop_count_d;
        end
    end

endmodule

// File: tb/tb_onehot_decoder_buf.sv
// Directed bench for onehot_decoder_buf with N=2.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_onehot_decoder_buf;

    logic       clk;
    logic       rst;
    logic       en;
    logic       in_valid;
    logic [1:0] in_code;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_onehot;
    logic       out_ready;
    logic [7:0] pop_count;

    int total;
    int passed;

    onehot_decoder_buf #(.N(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_valid   (in_valid),
        .in_code    (in_code),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_onehot (out_onehot),
        .out_ready  (out_ready),
        .pop_count  (pop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One line per handshake transaction seen at a rising edge.
    always @(posedge clk) begin
        if (!rst && in_valid && in_ready)
            $display("t=%0t push code=%0d", $time, in_code);
        if (!rst && out_valid && out_ready)
            $display("t=%0t pop  word=%b count_before=%0d", $time, out_onehot, pop_count);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] oh,
                           input logic [7:0] pc);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".onehot"}, 32'(out_onehot), 32'(oh));
        chk({tag, ".count"}, 32'(pop_count), 32'(pc));
    endtask

    initial begin
        logic [3:0] exp_word;
        total = 0;
        passed = 0;
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_code = 2'd0; out_ready = 1'b0;

        // Reset state; in_ready follows en during reset.
        #3;
        chk_out("reset", 1'b0, 4'b0000, 8'd0);
        chk("reset.in_ready_en0", 32'(in_ready), 32'd0);
        en = 1'b1;
        #1;
        chk("reset.in_ready_en1", 32'(in_ready), 32'd1);
        @(negedge clk); rst = 1'b0;
        tick();

        // Basic decode with streaming consumer.
        out_ready = 1'b1; in_valid = 1'b1; in_code = 2'd0;
        tick(); chk_out("dec0", 1'b1, 4'b0001, 8'd0); chk("dec0.in_ready", 32'(in_ready), 32'd1);
        in_code = 2'd1;
        tick(); chk_out("dec1", 1'b1, 4'b0010, 8'd1); chk("dec1.in_ready", 32'(in_ready), 32'd1);
        in_code = 2'd2;
        tick(); chk_out("dec2", 1'b1, 4'b0100, 8'd2); chk("dec2.in_ready", 32'(in_ready), 32'd1);
        in_code = 2'd3;
        tick(); chk_out("dec3", 1'b1, 4'b1000, 8'd3); chk("dec3.in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        tick(); chk_out("drain", 1'b0, 4'b0000, 8'd4);

        // Backpressure fill and ordering.
        out_ready = 1'b0; in_valid = 1'b1; in_code = 2'd3;
        tick(); chk_out("bp1", 1'b1, 4'b1000, 8'd4); chk("bp1.in_ready", 32'(in_ready), 32'd1);
        in_code = 2'd1;
        tick(); chk_out("bp2", 1'b1, 4'b1000, 8'd4); chk("bp2.in_ready", 32'(in_ready), 32'd0);
        in_code = 2'd2;
        tick(); chk_out("bp_full_hold", 1'b1, 4'b1000, 8'd4); chk("bp_full.in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick(); chk_out("bp_pop1", 1'b1, 4'b0010, 8'd5); chk("bp_pop1.in_ready", 32'(in_ready), 32'd1);
        tick(); chk_out("bp_pop2", 1'b1, 4'b0100, 8'd6);
        in_valid = 1'b0;
        tick(); chk_out("bp_empty", 1'b0, 4'b0000, 8'd7);

        // Simultaneous push/pop with one word buffered.
        out_ready = 1'b0; in_valid = 1'b1; in_code = 2'd0;
        tick(); chk_out("sim_head", 1'b1, 4'b0001, 8'd7);
        out_ready = 1'b1; in_code = 2'd2;
        tick(); chk_out("sim_pushpop", 1'b1, 4'b0100, 8'd8);
        in_valid = 1'b0;
        tick(); chk_out("sim_empty", 1'b0, 4'b0000, 8'd9);

        // Enable gating: no pushes while en is low, output side unaffected.
        out_ready = 1'b0; in_valid = 1'b1; in_code = 2'd3;
        tick(); chk_out("en_buf", 1'b1, 4'b1000, 8'd9);
        en = 1'b0; in_code = 2'd1;
        #1; chk("en_low.in_ready", 32'(in_ready), 32'd0);
        tick(); chk_out("en_low_hold", 1'b1, 4'b1000, 8'd9);
        out_ready = 1'b1;
        tick(); chk_out("en_low_drain", 1'b0, 4'b0000, 8'd10); chk("en_low_drain.in_ready", 32'(in_ready), 32'd0);
        en = 1'b1;
        #1; chk("en_high.in_ready", 32'(in_ready), 32'd1);
        tick(); chk_out("en_rise_push", 1'b1, 4'b0010, 8'd10);
        in_valid = 1'b0;
        tick(); chk_out("en_empty", 1'b0, 4'b0000, 8'd11);

        // Asynchronous reset while full.
        out_ready = 1'b0; in_valid = 1'b1; in_code = 2'd0;
        tick();
        in_code = 2'd1;
        tick(); chk("full.in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        #3; rst = 1'b1;
        #1; chk_out("async_rst", 1'b0, 4'b0000, 8'd0);
        #2; rst = 1'b0;
        in_valid = 1'b1; in_code = 2'd2;
        tick(); chk_out("post_rst", 1'b1, 4'b0100, 8'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); chk_out("post_rst_pop", 1'b0, 4'b0000, 8'd1);

        // Counter wrap: 257 streaming ticks deliver 256 words.
        #3; rst = 1'b1; #1; rst = 1'b0;
        chk("wrap_start.count", 32'(pop_count), 32'd0);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 257; i++) begin
            in_code = 2'((i - 1) % 4);
            tick();
            exp_word = 4'b0001 << ((i - 1) % 4);
            chk("wrap_word", 32'(out_onehot), 32'(exp_word));
        end
        chk("wrap_zero.count", 32'(pop_count), 32'd0);
        in_valid = 1'b0;
        tick(); chk_out("wrap_257th", 1'b0, 4'b0000, 8'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/onehot_decoder_buf.md
Name: onehot_decoder_buf

Overview:
Registered N-to-2^N one-hot decoder. It is the receive-side counterpart of the team's 4-to-2 priority-free encoder: it turns binary codes back into one-hot lines. Input and output use valid/ready handshakes, with a 2-entry output buffer, so a stalled consumer never drops a code. A pop counter gives the bench and system a cheap throughput check.

Parameters:
N, 2, code width in bits; one-hot output width is 2**N (legal range 1..4)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  decode enable; when low, no new codes are accepted
in_valid  input  1  producer has a code on in_code
in_code  input  N  binary code to decode
in_ready  output  1  block can accept a code this cycle
out_valid  output  1  out_onehot holds a decoded word
out_onehot  output  2**N  one-hot decoded word (head of buffer)
out_ready  input  1  consumer takes the head word this cycle
pop_count  output  8  number of words delivered, modulo 256

Behaviour:
- Reset (asserted): this is asynchronous and takes effect immediately, with no clock required.
  - Buffer is emptied (occupancy 0).
  - out_valid=0, out_onehot=0, pop_count=0.
  - Head and tail storage cleared to 0.
- in_ready is combinational: en AND (occupancy < 2). During reset, in_ready = en.
- Push: in_valid & in_ready at a rising edge. The value 1 << in_code is written to the tail entry.
- Pop: out_valid & out_ready at a rising edge. The head entry is retired, and pop_count increments by 1, wrapping from 255 to 0.
- out_valid = (occupancy != 0).
- out_onehot = head entry when occupancy != 0; otherwise 0. It is never X.
- Latency: a code pushed at edge k with the buffer empty shows on out_onehot/out_valid right after edge k, i.e. valid in cycle k+1.
- Ordering: strict FIFO. Words leave in acceptance order.
- Simultaneous push and pop:
  - Occupancy 1: occupancy stays 1. The old head leaves and the new word becomes head after the edge.
  - Occupancy 2: no push is possible (in_ready=0). The pop alone takes occupancy to 1.
- Full (occupancy 2): in_ready=0. in_valid is ignored, and in_code may change freely without effect.
- Empty with pop attempt: out_ready with out_valid=0 has no effect. pop_count does not change.
- en low:
  - in_ready=0 and no pushes occur.
  - Buffered words still drain normally through out_ready.
  - en has no effect on the output side.
- en rising while in_valid is high: push occurs at the first edge where en=1 and occupancy < 2.
- Output stability: while out_valid=1 and out_ready=0, out_onehot and out_valid hold unchanged.
- Reset mid-operation: all buffered words are discarded and outputs return to reset values. After release, the first accepted code behaves as from empty.
- Width rules:
  - Decode is total. Every N-bit code maps to exactly one asserted bit, so there is no invalid-code case.
  - The output always has exactly one bit set whenever out_valid=1.

Test Plan:
- Reset then basic decode (N=2): en=1, out_ready=1, push codes 0,1,2,3 on consecutive cycles.
  - Required: out_onehot = 0001, 0010, 0100, 1000, each one cycle after its push.
  - Required: pop_count=4, in_ready=1 throughout.
- Backpressure fill: out_ready=0, push codes 3 then 1.
  - Required: occupancy reaches 2 and in_ready=0; a third code (2) held on in_valid is not accepted.
  - Then out_ready=1: outputs 1000, then 0010, then 0100 (after the third is accepted). Order is preserved.
- Simultaneous push/pop at occupancy 1: head=0001 (code 0), out_ready=1 with push of code 2 in the same cycle.
  - Required: next cycle out_onehot=0100, out_valid=1, pop_count incremented by 1.
- Enable gating: with 1 word buffered, drop en and hold in_valid=1 with code 1.
  - Required: in_ready=0 and no push; the buffered word still drains with out_ready=1, then out_valid=0 and out_onehot=0.
  - Raising en pushes code 1 and gives out_onehot=0010 on the next cycle.
- Async reset mid-stream: buffer full, assert rst between clock edges.
  - Required: immediately out_valid=0, out_onehot=0, pop_count=0.
  - After release, pushing code 2 yields out_onehot=0100 next cycle.
- Counter wrap: perform 256 push/pop pairs with en=1, out_ready=1.
  - Required: pop_count returns to 0 and the 257th pop gives pop_count=1.
